dut_sig: RTL and testbench

DUT_SIG -- requirements
Module: dut_sig

---
 rtl/dut_sig_pkg.sv | 34 +++
 rtl/dut_sig_if.sv | 31 +++
 rtl/sig_fifo.sv | 75 +++++++
 rtl/dut_sig.sv | 108 ++++++++++
 tb/tb_dut_sig.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dut_sig_pkg.sv
// Shared defaults and the signature step function for the response-signature block.
// Latency: n/a (constants and a pure combinational function).
// Backpressure: n/a.
package dut_sig_pkg;

    localparam int DEF_IN_W  = 50;
    localparam int DEF_OUT_W = 30;
    localparam int DEF_DEPTH = 4;

    localparam logic [DEF_OUT_W-1:0] DEF_POLY = 30'h20000003;
    localparam logic [DEF_OUT_W-1:0] DEF_SEED = 30'h0;

    // The step function works on a fixed wide word so it can serve any OUT_W;
    // callers zero-extend their operands and truncate the result.
    localparam int SIG_MAX_W = 64;
    typedef logic [SIG_MAX_W-1:0] sig_word_t;

    // One signature step: shift left, bit 0 takes the parity of the tapped bits,
    // then fold in the delivered data. Bits at or above w are cleared so the bit
    // shifted out of the top of a w-bit register is dropped.
    function automatic sig_word_t sig_step(
        input sig_word_t sig,
        input sig_word_t poly,
        input sig_word_t dat,
        input int        w
    );
        sig_word_t r;
        sig_word_t keep;
        r    = {sig[SIG_MAX_W-2:0], ^(sig & poly)} ^ dat;
        keep = (w >= SIG_MAX_W) ? '1 : ((sig_word_t'(1) << w) - sig_word_t'(1));
        return r & keep;
    endfunction

endpackage

// File: rtl/dut_sig_if.sv
// Handshake/bus bundle for dut_sig: input vector channel, result channel, signature taps.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready and out_valid/out_ready handshakes; clear is a plain strobe.
interface dut_sig_if import dut_sig_pkg::*; #(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
    logic             clear;
    logic [OUT_W-1:0] sig;
    logic [15:0]      vec_cnt;

    // Stimulus/consumer side.
    modport master (
        output in_valid, in, out_ready, clear,
        input  in_ready, out_valid, out, sig, vec_cnt
    );

    // Signature block side.
    modport slave (
        input  in_valid, in, out_ready, clear,
        output in_ready, out_valid, out, sig, vec_cnt
    );

endinterface

// File: rtl/sig_fifo.sv
// Result FIFO: DEPTH x WIDTH circular buffer with valid/ready on both sides.
// Latency: 1 cycle write-to-read; a write and read in the same cycle both occur, even when full.
// Backpressure: wr_rdy_o drops when full unless the head is being read this cycle.
// Ports: clk, rst (sync, active high); wr_vld_i/wr_rdy_o/wr_dat_i write side;
//        rd_vld_o/rd_rdy_i/rd_dat_o read side; count_o current occupancy.
module sig_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_vld_i,
    output logic                       wr_rdy_o,
    input  logic [WIDTH-1:0]           wr_dat_i,
    output logic                       rd_vld_o,
    input  logic                       rd_rdy_i,
    output logic [WIDTH-1:0]           rd_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q;
    logic             wr_fire;
    logic             rd_fire;

    assign rd_vld_o = (count_q != '0);
    // A read in the same cycle frees the slot the write needs.
    assign wr_rdy_o = (count_q != CNT_W'(DEPTH)) | rd_rdy_i;
    assign wr_fire  = wr_vld_i & wr_rdy_o;
    assign rd_fire  = rd_vld_o & rd_rdy_i;
    assign count_o  = count_q;
    // When empty, keep showing the last delivered result rather than a stale slot.
    assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : last_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(wr_fire) - CNT_W'(rd_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (rd_fire) begin
                last_q <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

endmodule

// File: rtl/dut_sig.sv
// Response signature block: folds IN_W-bit vectors to OUT_W bits, buffers them, signs deliveries.
// Latency: 2 cycles acceptance-to-out_valid (evaluation stage, then FIFO).
// Backpressure: in_ready from registered occupancy (FIFO count + stage) only, never from out_ready.
// Ports: clk, rst (sync, active high); bus (dut_sig_if.slave) carries in/out handshakes,
//        clear strobe, running signature sig and delivered-vector count vec_cnt.
module dut_sig import dut_sig_pkg::*; #(
    parameter int               IN_W  = DEF_IN_W,
    parameter int               OUT_W = DEF_OUT_W,
    parameter int               DEPTH = DEF_DEPTH,
    parameter logic [OUT_W-1:0] MASK  = '0,
    parameter logic [OUT_W-1:0] POLY  = OUT_W'(DEF_POLY),
    parameter logic [OUT_W-1:0] SEED  = OUT_W'(DEF_SEED)
) (
    input  logic      clk,
    input  logic      rst,
    dut_sig_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [OUT_W-1:0] fold;
    logic             stage_v_q, stage_v_d;
    logic [OUT_W-1:0] stage_dat_q, stage_dat_d;
    logic             fifo_wr_rdy;
    logic             fifo_rd_vld;
    logic [OUT_W-1:0] fifo_rd_dat;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W:0]   occ;
    logic             in_fire;
    logic             deliver;
    logic [OUT_W-1:0] sig_q, sig_d;
    logic [15:0]      vec_cnt_q, vec_cnt_d;

    // Fold: output bit i is the parity of every input bit j with j mod OUT_W == i.
    for (genvar i = 0; i < OUT_W; i++) begin : g_fold
        logic [IN_W-1:0] sel;
        for (genvar j = 0; j < IN_W; j++) begin : g_sel
            assign sel[j] = ((j % OUT_W) == i) ? bus.in[j] : 1'b0;
        end
        assign fold[i] = MASK[i] ^ (^sel);
    end

    // Counting the stage slot guarantees the FIFO always has room when the stage drains.
    assign occ          = {1'b0, fifo_cnt} + (CNT_W+1)'(stage_v_q);
    assign bus.in_ready = (occ < (CNT_W+1)'(DEPTH));
    assign in_fire      = bus.in_valid & bus.in_ready;

    // No delivery may be seen during a reset cycle.
    assign bus.out_valid = fifo_rd_vld & ~rst;
    assign bus.out       = fifo_rd_dat;
    assign deliver       = bus.out_valid & bus.out_ready;

    assign bus.sig     = sig_q;
    assign bus.vec_cnt = vec_cnt_q;

    always_comb begin
        stage_v_d   = in_fire | (stage_v_q & ~fifo_wr_rdy);
        stage_dat_d = in_fire ? fold : stage_dat_q;
    end

    // clear beats a coincident delivery: the vector still leaves but is not absorbed.
    always_comb begin
        sig_d     = sig_q;
        vec_cnt_d = vec_cnt_q;
        if (bus.clear) begin
            sig_d     = SEED;
            vec_cnt_d = '0;
        end else if (deliver) begin
            sig_d = OUT_W'(sig_step(sig_word_t'(sig_q), sig_word_t'(POLY),
                                    sig_word_t'(fifo_rd_dat), OUT_W));
            if (vec_cnt_q != 16'hFFFF) begin
                vec_cnt_d = vec_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_v_q <= 1'b0;
            sig_q     <= SEED;
            vec_cnt_q <= '0;
        end else begin
            stage_v_q <= stage_v_d;
            sig_q     <= sig_d;
            vec_cnt_q <= vec_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        stage_dat_q <= stage_dat_d;
    end

    sig_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_vld_i (stage_v_q),
        .wr_rdy_o (fifo_wr_rdy),
        .wr_dat_i (stage_dat_q),
        .rd_vld_o (fifo_rd_vld),
        .rd_rdy_i (bus.out_ready & ~rst),
        .rd_dat_o (fifo_rd_dat),
        .count_o  (fifo_cnt)
    );

endmodule

// File: tb/tb_dut_sig.sv
// Self-checking bench for dut_sig: fold vector table plus latency, signature,
// backpressure, clear-on-delivery and mid-run reset sequences.
// Ports: none (top-level bench).
module tb_dut_sig;

    localparam int IN_W  = 50;
    localparam int OUT_W = 30;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    dut_sig_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    dut_sig #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH),
        .MASK  (30'h0),
        .POLY  (30'h20000003),
        .SEED  (30'h0)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [IN_W-1:0]  vin;
        logic [OUT_W-1:0] exp;
        string            name;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [IN_W-1:0] v, input logic [OUT_W-1:0] e,
                           input string n);
        tbl[i].vin  = v;
        tbl[i].exp  = e;
        tbl[i].name = n;
    endtask

    // Push one vector into a drained pipeline and wait (bounded) for its delivery.
    task automatic deliver(input logic [IN_W-1:0] v, output logic [OUT_W-1:0] got);
        bit ok;
        bus.out_ready = 1'b1;
        bus.in        = v;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        ok  = 1'b0;
        got = '0;
        for (int k = 0; k < 10 && !ok; k++) begin
            if (bus.out_valid) begin
                got = bus.out;
                ok  = 1'b1;
            end
            tick();
        end
        chk("deliver_in_time", 64'(ok), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [OUT_W-1:0] got;
        logic [OUT_W-1:0] got_q [5];
        int  idx;
        int  ndel;
        int  nvalid;
        bit  acc;
        bit  seen;

        set_vec(0, 50'h1,                30'h1,        "fold_bit0");
        set_vec(1, 50'h4000_0000,        30'h1,        "fold_bit30");
        set_vec(2, 50'h4000_0001,        30'h0,        "fold_bit0_bit30");
        set_vec(3, 50'h2_0000_0000_0000, 30'h80000,    "fold_bit49");
        set_vec(4, 50'h2000_0000,        30'h2000_0000, "fold_bit29");
        set_vec(5, 50'h3_FFFF_FFFF_FFFF, 30'h3FF0_0000, "fold_all_ones");
        set_vec(6, 50'h2000_0000_0000,   30'h8000,     "fold_bit45");
        set_vec(7, 50'h8_0000_0020,      30'h0,        "fold_bit5_bit35");
        set_vec(8, 50'h2_0000_0010_0000, 30'h18_0000,  "fold_bit20_bit49");
        set_vec(9, 50'h3,                30'h3,        "fold_low2");

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in       = '0;
        bus.out_ready = 1'b0;
        bus.clear    = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_vec_cnt",   64'(bus.vec_cnt),   64'(0));
        chk("rst_sig",       64'(bus.sig),       64'(0));
        rst = 1'b0;
        tick();

        // Latency: out_valid exactly two cycles after acceptance, for one cycle.
        bus.in        = 50'h1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        chk("lat_accept_rdy", 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        chk("lat_cyc1_out_valid", 64'(bus.out_valid), 64'(0));
        tick();
        chk("lat_cyc2_out_valid", 64'(bus.out_valid), 64'(1));
        chk("lat_cyc2_out",       64'(bus.out),       64'(1));
        tick();
        chk("lat_cyc3_out_valid", 64'(bus.out_valid), 64'(0));
        chk("lat_vec_cnt",        64'(bus.vec_cnt),   64'(1));

        // Signature: from SEED=0, two deliveries of 1 give 1 then 2.
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clr_sig",     64'(bus.sig),     64'(0));
        chk("clr_vec_cnt", 64'(bus.vec_cnt), 64'(0));
        deliver(50'h1, got);
        chk("sig1_out", 64'(got),     64'(1));
        chk("sig1_sig", 64'(bus.sig), 64'(30'h1));
        deliver(50'h4000_0000, got);
        chk("sig2_out",     64'(got),         64'(1));
        chk("sig2_sig",     64'(bus.sig),     64'(30'h2));
        chk("sig2_vec_cnt", 64'(bus.vec_cnt), 64'(2));

        // Fold table.
        for (int i = 0; i < 10; i++) begin
            deliver(tbl[i].vin, got);
            chk(tbl[i].name, 64'(got), 64'(tbl[i].exp));
        end
        chk("tbl_vec_cnt", 64'(bus.vec_cnt), 64'(12));

        // Backpressure: five vectors offered while stalled, only DEPTH accepted.
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = (idx < 5);
            bus.in       = IN_W'(idx + 1);
            acc          = bus.in_valid && bus.in_ready;
            tick();
            if (acc) idx++;
        end
        chk("bp_accepted",  64'(idx),           64'(4));
        chk("bp_in_ready",  64'(bus.in_ready),  64'(0));
        chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
        chk("bp_head",      64'(bus.out),       64'(1));
        tick();
        chk("bp_head_stable", 64'(bus.out),       64'(1));
        chk("bp_valid_held",  64'(bus.out_valid), 64'(1));

        bus.out_ready = 1'b1;
        ndel = 0;
        chk("bp_in_ready_pre", 64'(bus.in_ready), 64'(0));
        got_q[ndel] = bus.out;
        ndel++;
        tick();
        chk("bp_in_ready_post", 64'(bus.in_ready), 64'(1));
        for (int c = 0; c < 30 && ndel < 5; c++) begin
            bus.in_valid = (idx < 5);
            bus.in       = IN_W'(idx + 1);
            acc          = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                got_q[ndel] = bus.out;
                ndel++;
            end
            tick();
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        chk("bp_delivered", 64'(ndel), 64'(5));
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_order_%0d", k), 64'(got_q[k]), 64'(k + 1));
        end

        // clear coincident with a delivery: vector still appears, not absorbed.
        bus.in       = 50'h2_0000_0000_0000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (bus.out_valid) seen = 1'b1;
            else tick();
        end
        chk("clrdel_seen", 64'(seen), 64'(1));
        bus.clear = 1'b1;
        chk("clrdel_out", 64'(bus.out), 64'(30'h80000));
        tick();
        bus.clear = 1'b0;
        chk("clrdel_sig",       64'(bus.sig),       64'(0));
        chk("clrdel_vec_cnt",   64'(bus.vec_cnt),   64'(0));
        chk("clrdel_out_valid", 64'(bus.out_valid), 64'(0));

        // Mid-run reset with three buffered results.
        deliver(50'h1, got);
        chk("pre_rst_vec_cnt", 64'(bus.vec_cnt), 64'(1));
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in       = IN_W'(10 + c);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'(1));
        chk("mid_rst_vec_cnt",   64'(bus.vec_cnt),   64'(0));
        chk("mid_rst_sig",       64'(bus.sig),       64'(0));
        rst = 1'b0;
        bus.out_ready = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid) nvalid++;
            tick();
        end
        chk("post_rst_no_delivery", 64'(nvalid), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
